dec_ls_seq: RTL and testbench
=============================

// Module: dec_ls_seq
// PURPOSE
// - Parametrised load/store decode stage with sequencing. Sits between frontend issue slot and load/store unit.
// - Decodes D-form and X-form (opcd 31) loads/stores: byte/half/word, algebraic, update.
// - Expands multi-beat ops into per-cycle LSU control beats, stalling issue while sequencing.
// - Multi-beat ops: load-with-update (access beat + address-return beat) and lmw/stmw (one beat per register).
// PARAMETERS
// - IR_W    32  instruction width; opcd=ir[31:26], rt=ir[25:21], xo=ir[10:1]
// - NREG    32  GPR count; lmw/stmw run from rt to NREG-1
// - REG_W    5  register index width, clog2(NREG)
// - WORD_B   4  bytes per word; multiple-beat offset step
// - OFFS_W   8  width of ctrl_offset; must hold NREG*WORD_B-1
// PORTS
// - clk               in   1       clock
// - reset             in   1       asynchronous, active-high
// - inst_valid        in   1       issue slot valid
// - inst_ir           in   IR_W    instruction word
// - inst_ready        out  1       slot accepted this cycle (comb.)
// - ctrl_ready        in   1       LSU accepts current beat
// - ctrl_valid        out  1       beat valid (registered)
// - ctrl_we           out  1       store beat
// - ctrl_mode         out  2       0 null, 1 byte, 2 half, 3 word
// - ctrl_exts         out  1       sign-extend (lha, lhau, lhax, lhaux)
// - ctrl_do_request   out  1       issue memory request this beat
// - ctrl_return_dout  out  1       result = load data (else address)
// - ctrl_multiple     out  1       beat belongs to lmw/stmw
// - ctrl_first        out  1       first beat of instruction
// - ctrl_last         out  1       last beat of instruction
// - ctrl_reg          out  REG_W  target/source GPR of this beat
// - ctrl_offset       out  OFFS_W byte offset added to EA (multiple only, else 0)
// - ctrl_illegal      out  1       op not supported (see CONFIGURATION)
// BEHAVIOUR
// - Reset: every ctrl_* output 0, ctrl_mode=0, FSM=IDLE.
// - Advance: adv = ~ctrl_valid | ctrl_ready. Output regs load only when adv; otherwise hold.
// - inst_ready = (state==IDLE) & adv. Slot consumed iff inst_valid & inst_ready.
// - Latency 1: beat visible cycle after acceptance. Full throughput for single-beat ops.
// - Non-LS op accepted: ctrl_valid=1, we=0, mode=0, do_request=0, first=last=1 (pass-through beat).
// - Plain load/store, store-update: one beat. Fields:
//   - do_request=1, return_dout = load & ~update, first=last=1, reg=rt.
//   - Mode: byte (lbz/stb*), half (lh*/sth*), word otherwise.
// - Load-update (lwzu, lbzu, lhzu, lhau, and x-form ux): IDLE->UPD.
//   - Beat 0: do_request=1, return_dout=1, first=1.
//   - Beat 1 (UPD): do_request=0, return_dout=0, we=0, last=1, same mode/reg. Then UPD->IDLE on adv.
// - lmw/stmw: IDLE->MULT, beat counter r=rt.
//   - Each beat: mode=3, multiple=1, reg=r, offset=(r-rt)*WORD_B, we=stmw, return_dout=lmw.
//   - On adv, r increments; last=1 when r==NREG-1, then MULT->IDLE.
//   - rt=NREG-1: single beat, first=last=1.
// - No new slot accepted in UPD/MULT; new slot may be accepted same cycle the last beat retires (back-to-back).
// - Reset mid-sequence: immediate return to IDLE, outputs cleared, partial sequence abandoned.
// - ctrl_valid & ~ctrl_ready: all ctrl_* stable until accepted.
// CONFIGURATION
// - DEC_LS_MULTIPLE_EN defined: lmw/stmw sequenced as above.
// - Undefined: lmw/stmw emit one beat: ctrl_illegal=1, do_request=0, we=0, mode=0, first=last=1.
//   MULT state and counter not synthesised.
// - ctrl_illegal is 0 for all other ops in both builds.
// TESTING
// - Reset; lwz r3 -> one beat: mode=3, we=0, do_request=1, return_dout=1, first=last=1, reg=3.
// - lhau r5 -> beat0 mode=2, exts=1, do_request=1, return_dout=1; beat1 do_request=0, return_dout=0, last=1.
//   inst_ready=0 during beat0.
// - stbux (opcd 31, xo 247) -> one beat: we=1, mode=1, return_dout=0, do_request=1.
// - stmw r29, EN defined -> 3 beats reg 29/30/31, offset 0/4/8, we=1; last only on reg 31.
//   ctrl_ready low 2 cycles mid-sequence -> beat held unchanged.
// - lmw r31, EN undefined -> single beat ctrl_illegal=1, do_request=0; next lwz accepted following cycle.
// - Assert reset during lmw r0 beat 4 -> outputs 0 next edge; post-reset stw r1 decodes normally as single beat.

Source files
------------

// File: rtl/dec_ls_seq.sv
// dec_ls_seq -- load/store decode stage with multi-beat sequencing.
//
// This stage sits between the frontend issue slot and the load/store unit.
// It decodes D-form loads/stores and X-form loads/stores (opcd 31). Each
// accepted instruction becomes one or more registered control beats for the
// LSU:
//   - plain load/store and store-with-update: one beat
//   - load-with-update: an access beat, then an address-return beat
//   - lmw/stmw: one beat per register, from rt up to NREG-1
//     (only when DEC_LS_MULTIPLE_EN is defined)
// Any instruction that is not a load/store passes through as a null beat.
//
// Build option:
//   DEC_LS_MULTIPLE_EN  defined   : lmw/stmw are sequenced
//                       undefined : lmw/stmw emit a single ctrl_illegal beat
//
// Ports:
//   clk, reset        clock; asynchronous active-high reset
//   inst_valid/ir     issue slot; inst_ready is combinational (slot taken)
//   ctrl_ready        LSU accepts the current beat
//   ctrl_*            registered beat fields (valid, we, mode, exts,
//                     do_request, return_dout, multiple, first, last, reg,
//                     offset, illegal)
module dec_ls_seq #(
    parameter int IR_W   = 32,
    parameter int NREG   = 32,
    parameter int REG_W  = 5,
    parameter int WORD_B = 4,
    parameter int OFFS_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inst_valid,
    input  logic [IR_W-1:0]   inst_ir,
    output logic              inst_ready,
    input  logic              ctrl_ready,
    output logic              ctrl_valid,
    output logic              ctrl_we,
    output logic [1:0]        ctrl_mode,
    output logic              ctrl_exts,
    output logic              ctrl_do_request,
    output logic              ctrl_return_dout,
    output logic              ctrl_multiple,
    output logic              ctrl_first,
    output logic              ctrl_last,
    output logic [REG_W-1:0]  ctrl_reg,
    output logic [OFFS_W-1:0] ctrl_offset,
    output logic              ctrl_illegal
);

    localparam logic [1:0] MODE_NULL = 2'd0;
    localparam logic [1:0] MODE_BYTE = 2'd1;
    localparam logic [1:0] MODE_HALF = 2'd2;
    localparam logic [1:0] MODE_WORD = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UPD  = 2'd1
`ifdef DEC_LS_MULTIPLE_EN
        , ST_MULT = 2'd2
`endif
    } state_t;

    state_t state_reg, state_next;

    // ------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------
    logic [5:0]       opcd;
    logic [REG_W-1:0] rt;
    logic [9:0]       xo;

    assign opcd = inst_ir[31:26];
    assign rt   = inst_ir[25:21];
    assign xo   = inst_ir[10:1];

    // Register/displacement fields and Rc have no role in this stage.
    logic unused_bits;
    assign unused_bits = ^{inst_ir[20:11], inst_ir[0], 32'(NREG), 32'(WORD_B)};

    // ------------------------------------------------------------------
    // Decode
    // D-form opcodes 32..47 and the X-form xo values ((k << 5) | 23)
    // share the same 4-bit op index k:
    //   k[3:1]: 0 lwz, 1 lbz, 2 stw, 3 stb, 4 lhz, 5 lha, 6 sth, 7 lmw/stmw
    //   k[0]  : update form (or stmw for k[3:1]==7)
    // X-form has no counterpart to lmw/stmw, so k is limited to 0..13.
    // ------------------------------------------------------------------
    logic [3:0] dec_k;
    logic       dec_ls;
    logic       dec_mult;
    logic       dec_store;
    logic       dec_update;
    logic       dec_exts;
    logic [1:0] dec_mode;

    always_comb begin
        dec_k    = 4'd0;
        dec_ls   = 1'b0;
        dec_mult = 1'b0;
        if (opcd[5:4] == 2'b10) begin
            dec_k    = opcd[3:0];
            dec_ls   = (opcd[3:1] != 3'b111);
            dec_mult = (opcd[3:1] == 3'b111);
        end else if (opcd == 6'd31 && xo[4:0] == 5'd23 && !xo[9] && xo[8:5] <= 4'd13) begin
            dec_k  = xo[8:5];
            dec_ls = 1'b1;
        end
    end

    always_comb begin
        dec_update = dec_k[0];
        dec_store  = (dec_k[3:1] == 3'd2) || (dec_k[3:1] == 3'd3) || (dec_k[3:1] == 3'd6);
        dec_exts   = (dec_k[3:1] == 3'd5);
        case (dec_k[3:1])
            3'd1, 3'd3:       dec_mode = MODE_BYTE;
            3'd4, 3'd5, 3'd6: dec_mode = MODE_HALF;
            default:          dec_mode = MODE_WORD;
        endcase
    end

    // ------------------------------------------------------------------
    // Beat registers
    // ------------------------------------------------------------------
    logic              valid_reg, valid_next;
    logic              we_reg, we_next;
    logic [1:0]        mode_reg, mode_next;
    logic              exts_reg, exts_next;
    logic              do_request_reg, do_request_next;
    logic              return_dout_reg, return_dout_next;
    logic              multiple_reg, multiple_next;
    logic              first_reg, first_next;
    logic              last_reg, last_next;
    logic [REG_W-1:0]  reg_reg, reg_next;
    logic [OFFS_W-1:0] offset_reg, offset_next;
    logic              illegal_reg, illegal_next;

    // The output stage advances when it is empty or its beat is taken.
    logic adv;
    assign adv        = ~valid_reg | ctrl_ready;
    assign inst_ready = (state_reg == ST_IDLE) & adv;

    always_comb begin
        state_next       = state_reg;
        valid_next       = valid_reg;
        we_next          = we_reg;
        mode_next        = mode_reg;
        exts_next        = exts_reg;
        do_request_next  = do_request_reg;
        return_dout_next = return_dout_reg;
        multiple_next    = multiple_reg;
        first_next       = first_reg;
        last_next        = last_reg;
        reg_next         = reg_reg;
        offset_next      = offset_reg;
        illegal_next     = illegal_reg;

        if (adv) begin
            case (state_reg)
                ST_IDLE: begin
                    valid_next       = 1'b0;
                    we_next          = 1'b0;
                    mode_next        = MODE_NULL;
                    exts_next        = 1'b0;
                    do_request_next  = 1'b0;
                    return_dout_next = 1'b0;
                    multiple_next    = 1'b0;
                    first_next       = 1'b0;
                    last_next        = 1'b0;
                    reg_next         = '0;
                    offset_next      = '0;
                    illegal_next     = 1'b0;
                    if (inst_valid) begin
                        // Non-LS ops fall through as a null single beat.
                        valid_next = 1'b1;
                        first_next = 1'b1;
                        last_next  = 1'b1;
                        if (dec_ls) begin
                            do_request_next  = 1'b1;
                            we_next          = dec_store;
                            mode_next        = dec_mode;
                            exts_next        = dec_exts;
                            reg_next         = rt;
                            return_dout_next = ~dec_store & ~dec_update;
                            if (~dec_store & dec_update) begin
                                // Access beat now; address-return beat follows.
                                return_dout_next = 1'b1;
                                last_next        = 1'b0;
                                state_next       = ST_UPD;
                            end
                        end else if (dec_mult) begin
`ifdef DEC_LS_MULTIPLE_EN
                            do_request_next  = 1'b1;
                            mode_next        = MODE_WORD;
                            multiple_next    = 1'b1;
                            reg_next         = rt;
                            we_next          = dec_k[0];
                            return_dout_next = ~dec_k[0];
                            if (rt != REG_W'(NREG - 1)) begin
                                last_next  = 1'b0;
                                state_next = ST_MULT;
                            end
`else
                            illegal_next = 1'b1;
                            reg_next     = rt;
`endif
                        end
                    end
                end
                ST_UPD: begin
                    // Address-return beat: mode/reg/exts carried over.
                    we_next          = 1'b0;
                    do_request_next  = 1'b0;
                    return_dout_next = 1'b0;
                    first_next       = 1'b0;
                    last_next        = 1'b1;
                    state_next       = ST_IDLE;
                end
`ifdef DEC_LS_MULTIPLE_EN
                ST_MULT: begin
                    // ctrl_reg doubles as the beat counter; the offset
                    // tracks it in WORD_B steps from the starting register.
                    first_next  = 1'b0;
                    reg_next    = reg_reg + REG_W'(1);
                    offset_next = offset_reg + OFFS_W'(WORD_B);
                    if (reg_reg + REG_W'(1) == REG_W'(NREG - 1)) begin
                        last_next  = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
`endif
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            valid_reg       <= 1'b0;
            we_reg          <= 1'b0;
            mode_reg        <= MODE_NULL;
            exts_reg        <= 1'b0;
            do_request_reg  <= 1'b0;
            return_dout_reg <= 1'b0;
            multiple_reg    <= 1'b0;
            first_reg       <= 1'b0;
            last_reg        <= 1'b0;
            reg_reg         <= '0;
            offset_reg      <= '0;
            illegal_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            valid_reg       <= valid_next;
            we_reg          <= we_next;
            mode_reg        <= mode_next;
            exts_reg        <= exts_next;
            do_request_reg  <= do_request_next;
            return_dout_reg <= return_dout_next;
            multiple_reg    <= multiple_next;
            first_reg       <= first_next;
            last_reg        <= last_next;
            reg_reg         <= reg_next;
            offset_reg      <= offset_next;
            illegal_reg     <= illegal_next;
        end
    end

    assign ctrl_valid       = valid_reg;
    assign ctrl_we          = we_reg;
    assign ctrl_mode        = mode_reg;
    assign ctrl_exts        = exts_reg;
    assign ctrl_do_request  = do_request_reg;
    assign ctrl_return_dout = return_dout_reg;
    assign ctrl_multiple    = multiple_reg;
    assign ctrl_first       = first_reg;
    assign ctrl_last        = last_reg;
    assign ctrl_reg         = reg_reg;
    assign ctrl_offset      = offset_reg;
    assign ctrl_illegal     = illegal_reg;

endmodule

// File: tb/tb_dec_ls_seq.sv
// Directed testbench for dec_ls_seq. Inputs are driven and outputs sampled
// on the falling clock edge; the DUT registers on the rising edge.
module tb_dec_ls_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_valid;
    logic [31:0] inst_ir;
    logic        inst_ready;
    logic        ctrl_ready;
    logic        ctrl_valid;
    logic        ctrl_we;
    logic [1:0]  ctrl_mode;
    logic        ctrl_exts;
    logic        ctrl_do_request;
    logic        ctrl_return_dout;
    logic        ctrl_multiple;
    logic        ctrl_first;
    logic        ctrl_last;
    logic [4:0]  ctrl_reg;
    logic [7:0]  ctrl_offset;
    logic        ctrl_illegal;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dec_ls_seq dut (
        .clk              (clk),
        .reset            (reset),
        .inst_valid       (inst_valid),
        .inst_ir          (inst_ir),
        .inst_ready       (inst_ready),
        .ctrl_ready       (ctrl_ready),
        .ctrl_valid       (ctrl_valid),
        .ctrl_we          (ctrl_we),
        .ctrl_mode        (ctrl_mode),
        .ctrl_exts        (ctrl_exts),
        .ctrl_do_request  (ctrl_do_request),
        .ctrl_return_dout (ctrl_return_dout),
        .ctrl_multiple    (ctrl_multiple),
        .ctrl_first       (ctrl_first),
        .ctrl_last        (ctrl_last),
        .ctrl_reg         (ctrl_reg),
        .ctrl_offset      (ctrl_offset),
        .ctrl_illegal     (ctrl_illegal)
    );

    function automatic logic [31:0] d_op(input logic [5:0] opcd, input logic [4:0] rt);
        return {opcd, rt, 5'd1, 16'h0040};
    endfunction

    function automatic logic [31:0] x_op(input logic [9:0] xo, input logic [4:0] rt);
        return {6'd31, rt, 5'd1, 5'd2, xo, 1'b0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every beat field against hand-computed values.
    task automatic beat(input string tag, input logic [31:0] v, input logic [31:0] we,
                        input logic [31:0] mode, input logic [31:0] exts,
                        input logic [31:0] dreq, input logic [31:0] ret,
                        input logic [31:0] mult, input logic [31:0] first,
                        input logic [31:0] last, input logic [31:0] rg,
                        input logic [31:0] offs, input logic [31:0] ill);
        chk({tag, ".valid"},  32'(ctrl_valid),       v);
        chk({tag, ".we"},     32'(ctrl_we),          we);
        chk({tag, ".mode"},   32'(ctrl_mode),        mode);
        chk({tag, ".exts"},   32'(ctrl_exts),        exts);
        chk({tag, ".dreq"},   32'(ctrl_do_request),  dreq);
        chk({tag, ".ret"},    32'(ctrl_return_dout), ret);
        chk({tag, ".mult"},   32'(ctrl_multiple),    mult);
        chk({tag, ".first"},  32'(ctrl_first),       first);
        chk({tag, ".last"},   32'(ctrl_last),        last);
        chk({tag, ".reg"},    32'(ctrl_reg),         rg);
        chk({tag, ".offset"}, 32'(ctrl_offset),      offs);
        chk({tag, ".ill"},    32'(ctrl_illegal),     ill);
        $display("beat %s: valid=%0b we=%0b mode=%0d reg=%0d offset=%0d first=%0b last=%0b",
                 tag, ctrl_valid, ctrl_we, ctrl_mode, ctrl_reg, ctrl_offset, ctrl_first, ctrl_last);
    endtask

    initial begin
        reset      = 1'b1;
        inst_valid = 1'b0;
        inst_ir    = 32'd0;
        ctrl_ready = 1'b1;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        beat("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        #1 chk("reset.inst_ready", 32'(inst_ready), 1);

        // lwz r3
        @(negedge clk);
        inst_valid = 1'b1;
        inst_ir    = d_op(6'd32, 5'd3);
        #1 chk("lwz.inst_ready", 32'(inst_ready), 1);
        @(negedge clk);
        beat("lwz", 1, 0, 3, 0, 1, 1, 0, 1, 1, 3, 0, 0);

        // lhau r5, issued back-to-back
        inst_ir = d_op(6'd43, 5'd5);
        #1 chk("lhau.inst_ready", 32'(inst_ready), 1);
        @(negedge clk);
        beat("lhau.b0", 1, 0, 2, 1, 1, 1, 0, 1, 0, 5, 0, 0);
        inst_ir = x_op(10'd247, 5'd7);   // stbux r7 waits behind lhau
        #1 chk("lhau.b0.inst_ready", 32'(inst_ready), 0);
        @(negedge clk);
        beat("lhau.b1", 1, 0, 2, 1, 0, 0, 0, 0, 1, 5, 0, 0);
        #1 chk("lhau.b1.inst_ready", 32'(inst_ready), 1);

        // stbux r7
        @(negedge clk);
        beat("stbux", 1, 1, 1, 0, 1, 0, 0, 1, 1, 7, 0, 0);
        inst_valid = 1'b0;

        // Stage empties when nothing is issued
        @(negedge clk);
        chk("idle.valid", 32'(ctrl_valid), 0);

        // lhz r9 with the LSU stalling for two cycles
        inst_valid = 1'b1;
        inst_ir    = d_op(6'd40, 5'd9);
        @(negedge clk);
        beat("lhz", 1, 0, 2, 0, 1, 1, 0, 1, 1, 9, 0, 0);
        ctrl_ready = 1'b0;
        inst_ir    = d_op(6'd36, 5'd2);  // stw r2
        #1 chk("stall.inst_ready", 32'(inst_ready), 0);
        @(negedge clk);
        beat("lhz.hold1", 1, 0, 2, 0, 1, 1, 0, 1, 1, 9, 0, 0);
        @(negedge clk);
        beat("lhz.hold2", 1, 0, 2, 0, 1, 1, 0, 1, 1, 9, 0, 0);
        ctrl_ready = 1'b1;
        #1 chk("unstall.inst_ready", 32'(inst_ready), 1);
        @(negedge clk);
        beat("stw", 1, 1, 3, 0, 1, 0, 0, 1, 1, 2, 0, 0);

        // Non-LS op (addi) passes through as a null beat
        inst_ir = d_op(6'd14, 5'd4);
        @(negedge clk);
        beat("addi", 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);

        // lhaux r8 (X-form load-update, xo 375)
        inst_ir = x_op(10'd375, 5'd8);
        @(negedge clk);
        beat("lhaux.b0", 1, 0, 2, 1, 1, 1, 0, 1, 0, 8, 0, 0);
        inst_valid = 1'b0;
        @(negedge clk);
        beat("lhaux.b1", 1, 0, 2, 1, 0, 0, 0, 0, 1, 8, 0, 0);

`ifdef DEC_LS_MULTIPLE_EN
        // stmw r29: three beats, stall mid-sequence
        inst_valid = 1'b1;
        inst_ir    = d_op(6'd47, 5'd29);
        @(negedge clk);
        beat("stmw.r29", 1, 1, 3, 0, 1, 0, 1, 1, 0, 29, 0, 0);
        inst_valid = 1'b0;
        #1 chk("stmw.inst_ready", 32'(inst_ready), 0);
        @(negedge clk);
        beat("stmw.r30", 1, 1, 3, 0, 1, 0, 1, 0, 0, 30, 4, 0);
        ctrl_ready = 1'b0;
        @(negedge clk);
        beat("stmw.r30.hold1", 1, 1, 3, 0, 1, 0, 1, 0, 0, 30, 4, 0);
        @(negedge clk);
        beat("stmw.r30.hold2", 1, 1, 3, 0, 1, 0, 1, 0, 0, 30, 4, 0);
        ctrl_ready = 1'b1;
        @(negedge clk);
        beat("stmw.r31", 1, 1, 3, 0, 1, 0, 1, 0, 1, 31, 8, 0);

        // lmw r0, reset asserted while beat 4 is presented
        inst_valid = 1'b1;
        inst_ir    = d_op(6'd46, 5'd0);
        @(negedge clk);
        beat("lmw.r0", 1, 0, 3, 0, 1, 1, 1, 1, 0, 0, 0, 0);
        inst_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        beat("lmw.r4", 1, 0, 3, 0, 1, 1, 1, 0, 0, 4, 16, 0);
`else
        // lmw r31 is unsupported in this build
        inst_valid = 1'b1;
        inst_ir    = d_op(6'd46, 5'd31);
        @(negedge clk);
        beat("lmw.ill", 1, 0, 0, 0, 0, 0, 0, 1, 1, 31, 0, 1);
        inst_ir = d_op(6'd32, 5'd4);     // lwz r4 right behind it
        #1 chk("lmw.ill.inst_ready", 32'(inst_ready), 1);
        @(negedge clk);
        beat("lwz.r4", 1, 0, 3, 0, 1, 1, 0, 1, 1, 4, 0, 0);

        // stmw r29 is unsupported too
        inst_ir = d_op(6'd47, 5'd29);
        @(negedge clk);
        beat("stmw.ill", 1, 0, 0, 0, 0, 0, 0, 1, 1, 29, 0, 1);

        // lhau r6, reset asserted while its access beat is presented
        inst_ir = d_op(6'd43, 5'd6);
        @(negedge clk);
        beat("lhau.r6", 1, 0, 2, 1, 1, 1, 0, 1, 0, 6, 0, 0);
        inst_valid = 1'b0;
`endif
        reset = 1'b1;
        #1 beat("midreset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        beat("midreset.hold", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        inst_valid = 1'b1;
        inst_ir    = d_op(6'd36, 5'd1);  // stw r1
        #1 chk("postreset.inst_ready", 32'(inst_ready), 1);
        @(negedge clk);
        beat("stw.r1", 1, 1, 3, 0, 1, 0, 0, 1, 1, 1, 0, 0);
        inst_valid = 1'b0;
        @(negedge clk);
        chk("end.valid", 32'(ctrl_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
